// File: rtl/qreg_pkg.sv
// qreg_pkg: opcode and FSM types shared by the qreg_bank slice.
// Opcode constants are also exported as plain localparams for benches.
package qreg_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_INC  = 3'd1,
    OP_DEC  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_ROTL = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_e;

  localparam logic [2:0] OPC_LOAD = 3'd0;
  localparam logic [2:0] OPC_INC  = 3'd1;
  localparam logic [2:0] OPC_DEC  = 3'd2;
  localparam logic [2:0] OPC_AND  = 3'd3;
  localparam logic [2:0] OPC_OR   = 3'd4;
  localparam logic [2:0] OPC_XOR  = 3'd5;
  localparam logic [2:0] OPC_ROTL = 3'd6;
  localparam logic [2:0] OPC_CLR  = 3'd7;

endpackage

// File: rtl/qreg_alu.sv
// qreg_alu: combinational single-cycle datapath for qreg_bank.
// Define QREG_SAT_EN to saturate INC/DEC instead of wrapping.
module qreg_alu
  import qreg_pkg::*;
#(
  parameter int N = 8
) (
  input  op_e          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] sw,
  output logic [N-1:0] y,
  output logic         carry
);

  always_comb begin
    y     = a;
    carry = 1'b0;
    unique case (op)
      OP_LOAD: y = sw;
      OP_INC: begin
        if (&a) begin
          carry = 1'b1;
`ifdef QREG_SAT_EN
          y = a;
`else
          y = '0;
`endif
        end else begin
          y = a + N'(1);
        end
      end
      OP_DEC: begin
        if (a == '0) begin
          carry = 1'b1;
`ifdef QREG_SAT_EN
          y = a;
`else
          y = '1;
`endif
        end else begin
          y = a - N'(1);
        end
      end
      OP_AND:  y = a & sw;
      OP_OR:   y = a | sw;
      OP_XOR:  y = a ^ sw;
      // nonzero rotates are sequenced by the bank
      OP_ROTL: y = a;
      OP_CLR:  y = '0;
    endcase
  end

endmodule

// File: rtl/qreg_bank.sv
// qreg_bank: DEPTH x N register bank with handshaked opcodes, multi-cycle ROTL.
// Define QREG_SAT_EN to saturate INC/DEC instead of wrapping.
module qreg_bank
  import qreg_pkg::*;
#(
  parameter int N = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(N),
  localparam int SW_SEL = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [SW_SEL-1:0] sel,
  input  logic [N-1:0]      SW,
  input  logic [SW_SEL-1:0] rd_sel,
  output logic [N-1:0]      Qout,
  output logic              done,
  output logic              zero,
  output logic              carry
);

  logic [N-1:0]      regs_q [DEPTH];
  logic [N-1:0]      regs_d [DEPTH];
  state_e            state_q, state_d;
  logic [SW_SEL-1:0] rsel_q, rsel_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic              accept;
  logic [AW-1:0]     amt;
  logic [N-1:0]      alu_y;
  logic              alu_c;
  logic [N-1:0]      rot_v;
  logic [N-1:0]      rot_y;

  assign op_ready = (state_q == IDLE);
  assign accept   = op_valid && op_ready;
  assign amt      = SW[AW-1:0];
  assign rot_v    = regs_q[rsel_q];
  assign rot_y    = {rot_v[N-2:0], rot_v[N-1]};

  assign Qout  = regs_q[rd_sel];
  assign done  = done_q;
  assign zero  = zero_q;
  assign carry = carry_q;

  qreg_alu #(.N(N)) u_alu (
    .op    (op_e'(op)),
    .a     (regs_q[sel]),
    .sw    (SW),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OPC_ROTL && amt != '0) begin
            state_d = ROT;
            rsel_d  = sel;
            cnt_d   = amt;
          end else begin
            regs_d[sel] = alu_y;
            done_d      = 1'b1;
            zero_d      = (alu_y == '0);
            carry_d     = alu_c;
          end
        end
      end
      ROT: begin
        regs_d[rsel_q] = rot_y;
        cnt_d          = cnt_q - AW'(1);
        // flags settle only when the whole rotate has completed
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          zero_d  = (rot_y == '0);
          carry_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '{default: '0};
      state_q <= IDLE;
      rsel_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      rsel_q  <= rsel_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_qreg_bank.sv
// tb_qreg_bank: vector table, hand sequences and a randomized model check.
// Honours QREG_SAT_EN for INC/DEC expectations.
module tb_qreg_bank;
  import qreg_pkg::*;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [1:0] sel;
  logic [7:0] SW;
  logic [1:0] rd_sel;
  logic [7:0] Qout;
  logic       done;
  logic       zero;
  logic       carry;

  int n_tests;
  int n_fail;

  qreg_bank #(.N(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .sel      (sel),
    .SW       (SW),
    .rd_sel   (rd_sel),
    .Qout     (Qout),
    .done     (done),
    .zero     (zero),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] sw;
    logic [7:0] q;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vt[14];

  // behavioural model state
  logic [7:0] mreg [4];
  logic       mzero, mcarry, mdone;
  int         busy, rot_k, rot_j;
  logic [1:0] rot_sel;
  logic [7:0] rot_base;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [1:0] s, input logic [7:0] w);
    op_valid = v;
    op       = o;
    sel      = s;
    SW       = w;
    rd_sel   = s;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] t;
    t = {v, v} << k;
    return t[15:8];
  endfunction

  task automatic model_op(input logic [2:0] o, input logic [7:0] v,
                          input logic [7:0] w, output logic [7:0] r,
                          output logic c);
    int s;
    c = 1'b0;
    r = v;
    case (o)
      OPC_LOAD: r = w;
      OPC_INC: begin
        s = int'(v) + 1;
        if (s > 255) begin
          c = 1'b1;
`ifdef QREG_SAT_EN
          r = 8'hFF;
`else
          r = 8'(s - 256);
`endif
        end else r = 8'(s);
      end
      OPC_DEC: begin
        s = int'(v) - 1;
        if (s < 0) begin
          c = 1'b1;
`ifdef QREG_SAT_EN
          r = 8'h00;
`else
          r = 8'(s + 256);
`endif
        end else r = 8'(s);
      end
      OPC_AND:  r = v & w;
      OPC_OR:   r = v | w;
      OPC_XOR:  r = v ^ w;
      OPC_ROTL: r = rotl8(v, int'(w[2:0]));
      default:  r = 8'h00;
    endcase
  endtask

  task automatic model_edge();
    logic [7:0] r;
    logic       c;
    mdone = 1'b0;
    if (busy > 0) begin
      rot_j++;
      mreg[rot_sel] = rotl8(rot_base, rot_j);
      if (rot_j == rot_k) begin
        busy   = 0;
        mdone  = 1'b1;
        mzero  = (mreg[rot_sel] == 8'h00);
        mcarry = 1'b0;
      end
    end else if (op_valid) begin
      if (op == OPC_ROTL && SW[2:0] != 3'd0) begin
        busy     = 1;
        rot_k    = int'(SW[2:0]);
        rot_j    = 0;
        rot_sel  = sel;
        rot_base = mreg[sel];
      end else begin
        model_op(op, mreg[sel], SW, r, c);
        mreg[sel] = r;
        mdone     = 1'b1;
        mzero     = (r == 8'h00);
        mcarry    = c;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ready", op_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rst_qout", Qout, 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_seq [3];
    logic       pend;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 8'h00);

    vt[0]  = '{OPC_LOAD, 2'd2, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vt[1]  = '{OPC_AND,  2'd2, 8'h0F, 8'h05, 1'b0, 1'b0};
    vt[2]  = '{OPC_XOR,  2'd2, 8'h05, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{OPC_LOAD, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0};
`ifdef QREG_SAT_EN
    vt[4]  = '{OPC_INC,  2'd1, 8'h00, 8'hFF, 1'b0, 1'b1};
`else
    vt[4]  = '{OPC_INC,  2'd1, 8'h00, 8'h00, 1'b1, 1'b1};
`endif
    vt[5]  = '{OPC_CLR,  2'd1, 8'h5A, 8'h00, 1'b1, 1'b0};
`ifdef QREG_SAT_EN
    vt[6]  = '{OPC_DEC,  2'd1, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[7]  = '{OPC_OR,   2'd1, 8'h30, 8'h30, 1'b0, 1'b0};
`else
    vt[6]  = '{OPC_DEC,  2'd1, 8'h00, 8'hFF, 1'b0, 1'b1};
    vt[7]  = '{OPC_OR,   2'd1, 8'h30, 8'hFF, 1'b0, 1'b0};
`endif
    vt[8]  = '{OPC_LOAD, 2'd0, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vt[9]  = '{OPC_ROTL, 2'd0, 8'h08, 8'h3C, 1'b0, 1'b0};
    vt[10] = '{OPC_LOAD, 2'd3, 8'h10, 8'h10, 1'b0, 1'b0};
    vt[11] = '{OPC_INC,  2'd3, 8'h00, 8'h11, 1'b0, 1'b0};
    vt[12] = '{OPC_INC,  2'd3, 8'h00, 8'h12, 1'b0, 1'b0};
    vt[13] = '{OPC_DEC,  2'd3, 8'hFF, 8'h11, 1'b0, 1'b0};

    #12;
    rst = 1'b1;
    tick();
    do_reset();

    // back-to-back single-cycle table
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vt[i].op, vt[i].sel, vt[i].sw);
      #1;
      chk("vec_ready", op_ready, 1);
      tick();
      chk("vec_q", Qout, vt[i].q);
      chk("vec_done", done, 1);
      chk("vec_zero", zero, vt[i].z);
      chk("vec_carry", carry, vt[i].c);
    end
    drive(1'b0, 3'd0, 2'd0, 8'h00);
    tick();
    chk("idle_done", done, 0);

    // ROTL by 3 with a held INC behind it
    drive(1'b1, OPC_LOAD, 2'd0, 8'h81);
    tick();
    drive(1'b1, OPC_ROTL, 2'd0, 8'h03);
    tick();
    chk("rot_ready0", op_ready, 0);
    chk("rot_q0", Qout, 8'h81);
    chk("rot_done0", done, 0);
    drive(1'b1, OPC_INC, 2'd0, 8'h00);
    exp_seq[0] = 8'h03;
    exp_seq[1] = 8'h06;
    exp_seq[2] = 8'h0C;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rot_q", Qout, exp_seq[j]);
      chk("rot_ready", op_ready, (j == 2) ? 1 : 0);
      chk("rot_done", done, (j == 2) ? 1 : 0);
    end
    tick();
    chk("held_inc_q", Qout, 8'h0D);
    chk("held_inc_done", done, 1);
    chk("held_inc_carry", carry, 0);
    drive(1'b0, 3'd0, 2'd0, 8'h00);
    tick();
    chk("held_inc_once", Qout, 8'h0D);

    // reset in the middle of a ROTL by 5
    drive(1'b1, OPC_LOAD, 2'd3, 8'h77);
    tick();
    drive(1'b1, OPC_LOAD, 2'd1, 8'hFF);
    tick();
    drive(1'b1, OPC_INC, 2'd1, 8'h00);
    tick();
    chk("pre_rst_carry", carry, 1);
    drive(1'b1, OPC_ROTL, 2'd1, 8'h05);
    tick();
    drive(1'b0, 3'd0, 2'd1, 8'h00);
    tick();
    chk("mid_rot_ready", op_ready, 0);
    do_reset();
    drive(1'b1, OPC_LOAD, 2'd2, 8'h42);
    tick();
    chk("post_rst_q", Qout, 8'h42);
    chk("post_rst_done", done, 1);
    drive(1'b0, 3'd0, 2'd1, 8'h00);
    tick();
    tick();
    chk("post_rst_r1", Qout, 8'h00);
    chk("post_rst_ready", op_ready, 1);

    // randomized run against the model, from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mzero  = 1'b0;
    mcarry = 1'b0;
    mdone  = 1'b0;
    busy   = 0;
    pend   = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend) begin
        op_valid = ($urandom_range(0, 3) != 0);
        op       = 3'($urandom_range(0, 7));
        sel      = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0:       SW = 8'hFF;
          1:       SW = 8'h00;
          default: SW = 8'($urandom);
        endcase
      end
      rd_sel = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_q", Qout, mreg[rd_sel]);
      chk("rnd_ready", op_ready, (busy == 0) ? 1 : 0);
      chk("rnd_done", done, mdone);
      chk("rnd_zero", zero, mzero);
      chk("rnd_carry", carry, mcarry);
      pend = op_valid && (busy != 0);
      model_edge();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
